// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with next-PC ops and a return-address stack.
// Optional sticky overflow/underflow flags: define PC_STACK_ERR_EN.
module program_counter_stack #(
   parameter int                    ADDR_WIDTH   = 8,
   parameter int                    OFFSET_WIDTH = 8,
   parameter int                    STACK_DEPTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0,
   localparam int                   SP_W  = $clog2(STACK_DEPTH + 1),
   localparam int                   IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ce,
   input  logic [2:0]              op,
   input  logic [ADDR_WIDTH-1:0]   target,
   input  logic [OFFSET_WIDTH-1:0] offset,
   output logic [ADDR_WIDTH-1:0]   data_out,
   output logic [SP_W-1:0]         sp_count,
   output logic                    stack_full,
   output logic                    stack_empty
`ifdef PC_STACK_ERR_EN
   ,
   output logic                    err_ovf,
   output logic                    err_unf
`endif
);

   typedef enum logic [2:0] {
      OP_INC  = 3'd0,
      OP_HOLD = 3'd1,
      OP_JMP  = 3'd2,
      OP_BR   = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5,
      OP_SKIP = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, off_ext;
   logic [SP_W-1:0]       sp_q, sp_d;
   logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [IDX_W-1:0]      push_idx, pop_idx;
   logic                  push;
   logic                  call_full, ret_empty;

   assign pc_inc   = pc_q + ADDR_WIDTH'(1);
   assign off_ext  = ADDR_WIDTH'($signed(offset));
   assign push_idx = sp_q[IDX_W-1:0];
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

   assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp_q == '0);
   assign data_out    = pc_q;
   assign sp_count    = sp_q;

   always_comb begin
      pc_d      = pc_inc;
      sp_d      = sp_q;
      push      = 1'b0;
      call_full = 1'b0;
      ret_empty = 1'b0;
      unique case (op_e'(op))
         OP_HOLD: pc_d = pc_q;
         OP_JMP:  pc_d = target;
         OP_BR:   pc_d = pc_q + off_ext;
         OP_CALL: begin
            if (stack_full) begin
               call_full = 1'b1;
            end else begin
               push = 1'b1;
               pc_d = target;
               sp_d = sp_q + SP_W'(1);
            end
         end
         OP_RET: begin
            if (stack_empty) begin
               ret_empty = 1'b1;
            end else begin
               pc_d = stack_mem[pop_idx];
               sp_d = sp_q - SP_W'(1);
            end
         end
         OP_SKIP: pc_d = pc_q + ADDR_WIDTH'(2);
         OP_INC, OP_RSVD: pc_d = pc_inc;
         default: pc_d = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_ADDR;
         sp_q <= '0;
      end else if (ce) begin
         pc_q <= pc_d;
         sp_q <= sp_d;
      end
   end

   // Contents are don't-care after reset; only sp_q guards validity.
   always_ff @(posedge clk) begin
      if (ce && push) begin
         stack_mem[push_idx] <= pc_inc;
      end
   end

`ifdef PC_STACK_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else if (ce) begin
         if (call_full) err_ovf <= 1'b1;
         if (ret_empty) err_unf <= 1'b1;
      end
   end
`else
   logic unused_flags;
   assign unused_flags = call_full ^ ret_empty;
`endif

endmodule
